crack_sched: RTL

Parametrised key-search scheduler for the ARC4 cracker. Dispenses candidate keys one at a time to NUM_CORES single-key crack engines over the ready/enable protocol, collects pass/fail results, and stops on a hit. After a drain it reports the smallest valid key, independent of core latency. It sits between the board top level (HEX/LEDR display, plaintext readout) and an array of crack engines. It replaces the fixed two-engine search with a configurable width and core count.

---
 rtl/crack_sched_pkg.sv | 20 ++
 rtl/crack_sched_prio_pick.sv | 24 ++
 rtl/crack_sched.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/crack_sched_pkg.sv
// Shared types and defaults for the ARC4 key-search scheduler.
package crack_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } sched_state_t;

  localparam int DEF_KEY_W     = 24;
  localparam int DEF_NUM_CORES = 2;

  typedef logic [DEF_KEY_W-1:0] key_t;

  // Index width for an N-entry vector; a single entry still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/crack_sched_prio_pick.sv
// Lowest-index set-bit picker: returns the index of the first request and a found flag.
module prio_pick
  import crack_pkg::*;
#(
  parameter  int N  = 2,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  output logic [IW-1:0] idx,
  output logic          found
);

  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = IW'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/crack_sched.sv
// Key-search scheduler: hands ascending candidate keys to NUM_CORES crack engines
// and reports the smallest hitting key once every in-flight job has drained.
//
// state | meaning
// IDLE  | rdy high, last result held, waiting for en
// RUN   | one dispatch per cycle to the lowest free core, results collected
// DRAIN | no dispatches, wait for every busy core to finish, then publish
module crack_sched
  import crack_pkg::*;
#(
  parameter  int NUM_CORES = DEF_NUM_CORES,
  parameter  int KEY_W     = DEF_KEY_W,
  localparam int CW        = idx_w(NUM_CORES)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  output logic                       rdy,
  output logic                       key_valid,
  output logic [KEY_W-1:0]           key,
  output logic [CW-1:0]              win_ch,
  output logic [NUM_CORES-1:0]       core_en,
  output logic [NUM_CORES*KEY_W-1:0] core_key,
  input  logic [NUM_CORES-1:0]       core_rdy,
  input  logic [NUM_CORES-1:0]       core_done,
  input  logic [NUM_CORES-1:0]       core_hit
);

  sched_state_t         state;
  logic [KEY_W:0]       next_key;
  logic [NUM_CORES-1:0] busy;
  logic [KEY_W-1:0]     ckey [NUM_CORES];
  logic                 hit_seen;
  logic [KEY_W-1:0]     best_key;
  logic [CW-1:0]        best_ch;

  logic [NUM_CORES-1:0] free;
  logic [NUM_CORES-1:0] fin;
  logic [NUM_CORES-1:0] hits;
  logic [NUM_CORES-1:0] is_min;
  logic [NUM_CORES-1:0] disp_mask;
  logic [CW-1:0]        disp_idx;
  logic                 disp_ok;
  logic [CW-1:0]        hit_idx;
  logic                 hit_ok;
  logic [KEY_W-1:0]     hit_key;
  logic                 do_disp;
  logic                 last_key;
  logic                 new_best;

  assign free = core_rdy & ~busy;
  // Completions from cores we never dispatched to are ignored.
  assign fin  = core_done & busy;
  assign hits = fin & core_hit;

  prio_pick #(.N(NUM_CORES)) u_disp_pick (
    .req   (free),
    .idx   (disp_idx),
    .found (disp_ok)
  );

  // A hitting core is the minimum when no other simultaneous hit holds a smaller key.
  always_comb begin
    is_min = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      is_min[i] = hits[i];
      for (int j = 0; j < NUM_CORES; j++) begin
        if (j != i && hits[j] && (ckey[j] < ckey[i])) is_min[i] = 1'b0;
      end
    end
  end

  prio_pick #(.N(NUM_CORES)) u_hit_pick (
    .req   (is_min),
    .idx   (hit_idx),
    .found (hit_ok)
  );

  always_comb begin
    hit_key = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (hit_idx == CW'(i)) hit_key = ckey[i];
    end
  end

  assign new_best = hit_ok && (!hit_seen || (hit_key < best_key));
  // next_key carries an extra bit so exhaustion is visible instead of wrapping.
  assign do_disp  = (state == RUN) && disp_ok && !next_key[KEY_W];
  assign last_key = (next_key == {1'b0, {KEY_W{1'b1}}});

  always_comb begin
    disp_mask = '0;
    if (do_disp) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (disp_idx == CW'(i)) disp_mask[i] = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_key_out
    assign core_key[g*KEY_W +: KEY_W] = ckey[g];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rdy       <= 1'b1;
      key_valid <= 1'b0;
      key       <= '0;
      win_ch    <= '0;
      core_en   <= '0;
      busy      <= '0;
      next_key  <= '0;
      hit_seen  <= 1'b0;
      best_key  <= '0;
      best_ch   <= '0;
      for (int i = 0; i < NUM_CORES; i++) ckey[i] <= '0;
    end else begin
      core_en <= '0;
      unique case (state)
        IDLE: begin
          if (en) begin
            state     <= RUN;
            rdy       <= 1'b0;
            key_valid <= 1'b0;
            key       <= '0;
            win_ch    <= '0;
            busy      <= '0;
            next_key  <= '0;
            hit_seen  <= 1'b0;
            best_key  <= '0;
            best_ch   <= '0;
          end
        end
        RUN, DRAIN: begin
          busy <= (busy & ~fin) | disp_mask;
          if (new_best) begin
            hit_seen <= 1'b1;
            best_key <= hit_key;
            best_ch  <= hit_idx;
          end
          if (state == RUN) begin
            core_en <= disp_mask;
            for (int i = 0; i < NUM_CORES; i++) begin
              if (disp_mask[i]) ckey[i] <= next_key[KEY_W-1:0];
            end
            if (do_disp) next_key <= next_key + (KEY_W+1)'(1);
            // A dispatch in the same cycle as the first hit still goes out.
            if (hit_ok || (do_disp && last_key)) state <= DRAIN;
          end else if (busy == '0) begin
            state     <= IDLE;
            rdy       <= 1'b1;
            key_valid <= hit_seen;
            key       <= hit_seen ? best_key : '0;
            win_ch    <= hit_seen ? best_ch : '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
